nx_egress_scheduler: RTL

// - Shares one outbound message stream between two requesters: bypass traffic (arbitrated

---
 rtl/nx_pkg.sv | 13 +
 rtl/nx_stream_reg.sv | 64 ++++++
 rtl/nx_egress_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/nx_pkg.sv
// rtl/nx_pkg.sv - shared types for the node egress path
//
// Purpose: source identifiers used by the egress scheduler and its output slice.
package nx_pkg;

    typedef enum logic {
        SRC_BYPASS   = 1'b0,
        SRC_INTERNAL = 1'b1
    } nx_egress_src_t;

    localparam int NX_STAT_WIDTH = 32;

endpackage

// File: rtl/nx_stream_reg.sv
// rtl/nx_stream_reg.sv - single-entry valid/ready register slice carrying data and source
//
// Purpose: registers one beat plus its source tag; accepts a new beat whenever it is
// empty or its current beat leaves in the same cycle, so one beat/cycle is sustained.
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   in_data_i/in_src_i          incoming beat and its source
//   in_valid_i/in_ready_o       incoming handshake (in_ready_o is the can-load condition)
//   out_data_o/out_src_o        held beat and source
//   out_valid_o/out_ready_i     outgoing handshake
module nx_stream_reg
    import nx_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  nx_egress_src_t   in_src_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output nx_egress_src_t   out_src_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [WIDTH-1:0] data_q, data_d;
    nx_egress_src_t   src_q, src_d;
    logic             valid_q, valid_d;

    assign in_ready_o = !valid_q || out_ready_i;

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (in_ready_o) begin
            // Either empty or draining this cycle: take whatever is offered.
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
                src_d  = in_src_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            src_q   <= SRC_BYPASS;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_src_o   = src_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/nx_egress_scheduler.sv
// rtl/nx_egress_scheduler.sv - weighted round-robin egress scheduler for bypass and internal traffic
//
// Purpose: merges bypass and internal message streams onto one registered output.
// While both sources wait, the current source keeps the grant for at most
// max(weight,1) consecutive beats before the other source takes over.
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   byp_data_i/byp_valid_i/byp_ready_o    bypass stream in
//   int_data_i/int_valid_i/int_ready_o    internal stream in
//   cfg_byp_weight_i/cfg_int_weight_i     burst limits (0 behaves as 1)
//   out_data_o/out_src_o/out_valid_o/out_ready_i  registered output stream
//   idle_o                                nothing held and nothing offered
// Optional (NX_EGRESS_SCHED_STATS_EN): stat_clear_i, stat_byp_o, stat_int_o
//   per-source accepted-beat counters.
module nx_egress_scheduler
    import nx_pkg::*;
#(
    parameter int STREAM_WIDTH = 32,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] byp_data_i,
    input  logic                    byp_valid_i,
    output logic                    byp_ready_o,
    input  logic [STREAM_WIDTH-1:0] int_data_i,
    input  logic                    int_valid_i,
    output logic                    int_ready_o,
    input  logic [WEIGHT_WIDTH-1:0] cfg_byp_weight_i,
    input  logic [WEIGHT_WIDTH-1:0] cfg_int_weight_i,
    output logic [STREAM_WIDTH-1:0] out_data_o,
    output logic                    out_src_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
`ifdef NX_EGRESS_SCHED_STATS_EN
    input  logic                    stat_clear_i,
    output logic [NX_STAT_WIDTH-1:0] stat_byp_o,
    output logic [NX_STAT_WIDTH-1:0] stat_int_o,
`endif
    output logic                    idle_o
);

    localparam logic [WEIGHT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WEIGHT_WIDTH-1:0] CNT_ONE = WEIGHT_WIDTH'(1);

    nx_egress_src_t          cur_src_q, cur_src_d;
    logic [WEIGHT_WIDTH-1:0] count_q, count_d;

    logic [WEIGHT_WIDTH-1:0] eff_byp_w, eff_int_w, cur_w;
    nx_egress_src_t          sel_src, other_src;
    logic                    can_load, grant_ok, xfer;
    logic [STREAM_WIDTH-1:0] sel_data;
    nx_egress_src_t          out_src_e;

    assign eff_byp_w = (cfg_byp_weight_i == '0) ? CNT_ONE : cfg_byp_weight_i;
    assign eff_int_w = (cfg_int_weight_i == '0) ? CNT_ONE : cfg_int_weight_i;
    assign cur_w     = (cur_src_q == SRC_BYPASS) ? eff_byp_w : eff_int_w;
    assign other_src = (cur_src_q == SRC_BYPASS) ? SRC_INTERNAL : SRC_BYPASS;

    always_comb begin
        sel_src = cur_src_q;
        if (byp_valid_i && int_valid_i) begin
            sel_src = (count_q < cur_w) ? cur_src_q : other_src;
        end else if (byp_valid_i) begin
            sel_src = SRC_BYPASS;
        end else if (int_valid_i) begin
            sel_src = SRC_INTERNAL;
        end
    end

    // Readies are held low in reset so nothing is consumed that would be dropped.
    assign grant_ok    = can_load && !rst_i;
    assign byp_ready_o = grant_ok && byp_valid_i && (sel_src == SRC_BYPASS);
    assign int_ready_o = grant_ok && int_valid_i && (sel_src == SRC_INTERNAL);
    assign xfer        = byp_ready_o || int_ready_o;
    assign sel_data    = (sel_src == SRC_INTERNAL) ? int_data_i : byp_data_i;

    always_comb begin
        cur_src_d = cur_src_q;
        count_d   = count_q;
        if (xfer) begin
            if (sel_src == cur_src_q) begin
                count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_ONE;
            end else begin
                cur_src_d = sel_src;
                count_d   = CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_src_q <= SRC_BYPASS;
            count_q   <= '0;
        end else begin
            cur_src_q <= cur_src_d;
            count_q   <= count_d;
        end
    end

    nx_stream_reg #(
        .WIDTH (STREAM_WIDTH)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (sel_data),
        .in_src_i    (sel_src),
        .in_valid_i  (xfer),
        .in_ready_o  (can_load),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_e),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    assign out_src_o = out_src_e;
    assign idle_o    = !out_valid_o && !byp_valid_i && !int_valid_i;

`ifdef NX_EGRESS_SCHED_STATS_EN
    logic [NX_STAT_WIDTH-1:0] stat_byp_q, stat_byp_d;
    logic [NX_STAT_WIDTH-1:0] stat_int_q, stat_int_d;

    // Clear wins over a same-cycle increment.
    always_comb begin
        stat_byp_d = stat_byp_q + NX_STAT_WIDTH'(byp_ready_o);
        stat_int_d = stat_int_q + NX_STAT_WIDTH'(int_ready_o);
        if (stat_clear_i) begin
            stat_byp_d = '0;
            stat_int_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_byp_q <= '0;
            stat_int_q <= '0;
        end else begin
            stat_byp_q <= stat_byp_d;
            stat_int_q <= stat_int_d;
        end
    end

    assign stat_byp_o = stat_byp_q;
    assign stat_int_o = stat_int_q;
`endif

endmodule
